// File: rtl/fsm_ctrl_core.sv
// Four-state Moore job sequencer (IDLE/RUN/DONE/FAULT) with registered busy/valid/fault status.
// Optional RUN watchdog enabled by defining FSM_TIMEOUT_EN.
module fsm_ctrl_core #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic done,
  input  logic error,
  output logic busy,
  output logic valid,
  output logic fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DONE  = 2'b10,
    FAULT = 2'b11
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        busy_q, valid_q, fault_q;
  logic        timeout_hit;

`ifdef FSM_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == TO_LAST);

  // Counter holds zero outside RUN, so RUN entry always starts from zero.
  always_comb begin
    cnt_d = 16'd0;
    if (state_q == RUN && state_d == RUN) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^TO_LAST;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (error)      state_d = FAULT;
        else if (start) state_d = RUN;
      end
      RUN: begin
        if (error)            state_d = FAULT;
        else if (done)        state_d = DONE;
        else if (timeout_hit) state_d = FAULT;
      end
      DONE: begin
        if (error) state_d = FAULT;
        else       state_d = IDLE;
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Status flops track the next state so they always equal a decode of state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      valid_q <= (state_d == DONE);
      fault_q <= (state_d == FAULT);
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_fsm_ctrl_core.sv
// Randomized and directed bench for fsm_ctrl_core against a job-level behavioural model.
module tb_fsm_ctrl_core;

  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic done = 1'b0;
  logic error = 1'b0;
  logic busy, valid, fault;

  int n_cmp = 0;
  int n_bad = 0;

  fsm_ctrl_core #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done),
    .error (error),
    .busy  (busy),
    .valid (valid),
    .fault (fault)
  );

  always #5 clk = ~clk;

  // Job-level model: a running job, how many RUN cycles it has occupied,
  // a pending completion pulse, and a latched fault.
  bit m_running, m_pulse, m_faulted;
  int m_runcyc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_running = 0; m_pulse = 0; m_faulted = 0; m_runcyc = 0;
    end else if (m_faulted) begin
      m_faulted = 1;
    end else if (error) begin
      m_faulted = 1; m_running = 0; m_pulse = 0;
    end else if (m_pulse) begin
      m_pulse = 0;
    end else if (m_running) begin
      if (done) begin
        m_running = 0; m_pulse = 1;
      end else begin
`ifdef FSM_TIMEOUT_EN
        if (m_runcyc == T) begin
          m_running = 0; m_faulted = 1;
        end else begin
          m_runcyc++;
        end
`else
        m_runcyc++;
`endif
      end
    end else if (start) begin
      m_running = 1; m_runcyc = 1;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model compare on every falling edge, away from the active edge.
  always @(negedge clk) begin
    check("model_busy", busy, m_running);
    check("model_valid", valid, m_pulse);
    check("model_fault", fault, m_faulted);
  end

  task automatic step(input logic s, input logic d, input logic e);
    start = s; done = d; error = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect3(input string name, input logic b, input logic v, input logic f);
    check({name, "_busy"}, busy, b);
    check({name, "_valid"}, valid, v);
    check({name, "_fault"}, fault, f);
  endtask

  // Asserts reset mid-cycle, confirms outputs clear without a clock, then releases.
  task automatic async_reset(input string name);
    #2 reset = 1'b0;
    start = 0; done = 0; error = 0;
    #1 expect3(name, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    expect3("in_reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) step(0, 0, 0);
    expect3("idle_after_reset", 1'b0, 1'b0, 1'b0);

    // Basic job: done ignored in IDLE, start ignored in RUN.
    step(0, 1, 0);
    expect3("done_in_idle", 1'b0, 1'b0, 1'b0);
    step(1, 0, 0);
    expect3("start_lat", 1'b1, 1'b0, 1'b0);
    step(1, 0, 0);
    check("run_hold1", busy, 1'b1);
    step(0, 0, 0);
    check("run_hold2", busy, 1'b1);
    step(0, 1, 0);
    expect3("done_lat", 1'b0, 1'b1, 1'b0);
    step(1, 0, 0);
    expect3("start_in_done_dropped", 1'b0, 1'b0, 1'b0);
    step(1, 0, 0);
    check("back_to_back", busy, 1'b1);
    step(0, 1, 0);
    check("min_job_valid", valid, 1'b1);
    step(0, 0, 0);

    // Error in IDLE: sticky fault.
    step(0, 0, 1);
    expect3("err_idle", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(logic'(i % 2), logic'((i + 1) % 2), 1'b0);
    expect3("fault_sticky", 1'b0, 1'b0, 1'b1);
    async_reset("fault_clear");
    step(0, 0, 0);

    // Error beats done in RUN.
    step(1, 0, 0);
    step(0, 1, 1);
    expect3("err_over_done", 1'b0, 1'b0, 1'b1);
    async_reset("fault_clear2");
    step(0, 0, 0);

    // Reset mid-RUN, then a new job.
    step(1, 0, 0);
    step(0, 0, 0);
    async_reset("reset_mid_run");
    step(1, 0, 0);
    check("restart_after_reset", busy, 1'b1);
    step(0, 1, 0);
    check("restart_valid", valid, 1'b1);
    step(0, 0, 0);

`ifdef FSM_TIMEOUT_EN
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      check("wd_busy", busy, 1'b1);
    end
    step(0, 0, 0);
    expect3("wd_fault", 1'b0, 1'b0, 1'b1);
    async_reset("wd_clear");
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(0, 1, 0);
    expect3("wd_done_wins", 1'b0, 1'b1, 1'b0);
    step(0, 0, 0);
`else
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0);
    expect3("no_watchdog", 1'b1, 1'b0, 1'b0);
    step(0, 1, 0);
    check("no_watchdog_valid", valid, 1'b1);
    step(0, 0, 0);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rand_reset");
      end else begin
        step(logic'($urandom_range(0, 2) == 0),
             logic'($urandom_range(0, 3) == 0),
             logic'($urandom_range(0, 49) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
